// File: rtl/clock_set_ctrl.sv
// Mode/set controller and alarm scheduler for the 12-hour BCD clock timer.
// Turns the active-low mode/inc keys into single-cycle timer increment commands,
// gates the 1 Hz tick while setting, and runs a BCD alarm with a time-limited ring.
module clock_set_ctrl #(
    parameter int unsigned RING_SEC = 30
) (
    input  logic       iclk,
    input  logic       irst_n,
    input  logic       iclk_sec,
    input  logic       ikey_mode,
    input  logic       ikey_inc,
    input  logic [7:0] ihour,
    input  logic [7:0] imin,
    input  logic [7:0] isec,
    output logic       otick,
    output logic       ohour_inc,
    output logic       omin_inc,
    output logic [2:0] omode,
    output logic       oblink,
    output logic [7:0] oal_hour,
    output logic [7:0] oal_min,
    output logic       oalarm_en,
    output logic       oring
);

    typedef enum logic [2:0] {
        StRun     = 3'd0,
        StSetHour = 3'd1,
        StSetMin  = 3'd2,
        StAlHour  = 3'd3,
        StAlMin   = 3'd4
    } state_e;

    localparam logic [7:0] RingLoad = RING_SEC[7:0];

    state_e     state_q, state_d;
    logic [2:0] mode_dly_q, inc_dly_q, sec_dly_q;
    logic       hour_inc_q, hour_inc_d;
    logic       min_inc_q, min_inc_d;
    logic [7:0] al_hour_q, al_hour_d;
    logic [7:0] al_min_q, al_min_d;
    logic       alarm_en_q, alarm_en_d;
    logic       ring_q, ring_d;
    logic [7:0] ring_cnt_q, ring_cnt_d;
    logic       match_q, match;
    logic       mode_ev, inc_ev, sec_ev;
    logic       dismiss;

    // BCD increment with wrap from max back to 00; out-of-range digits are not corrected
    function automatic logic [7:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
        logic [7:0] res;
        if (val == max) begin
            res = 8'h00;
        end else if (val[3:0] == 4'd9) begin
            res = {val[7:4] + 4'd1, 4'd0};
        end else begin
            res = {val[7:4], val[3:0] + 4'd1};
        end
        return res;
    endfunction

    // Falling-edge detect on the synchronised async inputs
    assign mode_ev = mode_dly_q[2] & ~mode_dly_q[1];
    assign inc_ev  = inc_dly_q[2] & ~inc_dly_q[1];
    assign sec_ev  = sec_dly_q[2] & ~sec_dly_q[1];

    assign match = (state_q == StRun) & alarm_en_q & (ihour == al_hour_q) &
                   (imin == al_min_q) & (isec == 8'h00);

    // Three-stage synchronisers for keys and the 1 Hz input
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            mode_dly_q <= 3'b111;
            inc_dly_q  <= 3'b111;
            sec_dly_q  <= 3'b111;
        end else begin
            mode_dly_q <= {mode_dly_q[1:0], ikey_mode};
            inc_dly_q  <= {inc_dly_q[1:0], ikey_inc};
            sec_dly_q  <= {sec_dly_q[1:0], iclk_sec};
        end
    end

    // Mode FSM and key command decode; mode beats inc, ring dismissal beats both
    always_comb begin
        state_d    = state_q;
        hour_inc_d = 1'b0;
        min_inc_d  = 1'b0;
        al_hour_d  = al_hour_q;
        al_min_d   = al_min_q;
        alarm_en_d = alarm_en_q;
        dismiss    = 1'b0;
        case (state_q)
            StRun: begin
                if (mode_ev) begin
                    if (ring_q) dismiss = 1'b1;
                    else        state_d = StSetHour;
                end else if (inc_ev) begin
                    if (ring_q) dismiss = 1'b1;
                    else        alarm_en_d = ~alarm_en_q;
                end
            end
            StSetHour: begin
                if (mode_ev)     state_d = StSetMin;
                else if (inc_ev) hour_inc_d = 1'b1;
            end
            StSetMin: begin
                if (mode_ev)     state_d = StAlHour;
                else if (inc_ev) min_inc_d = 1'b1;
            end
            StAlHour: begin
                if (mode_ev)     state_d = StAlMin;
                else if (inc_ev) al_hour_d = bcd_inc(al_hour_q, 8'h11);
            end
            StAlMin: begin
                if (mode_ev)     state_d = StRun;
                else if (inc_ev) al_min_d = bcd_inc(al_min_q, 8'h59);
            end
            default: state_d = StRun;
        endcase
    end

    // Ring start on match rise, countdown on 1 Hz falling edges, early stop on dismiss/disarm
    always_comb begin
        ring_d     = ring_q;
        ring_cnt_d = ring_cnt_q;
        if (dismiss || (alarm_en_q && !alarm_en_d)) begin
            ring_d = 1'b0;
        end else if (ring_q) begin
            if (sec_ev) begin
                if (ring_cnt_q <= 8'd1) begin
                    ring_d     = 1'b0;
                    ring_cnt_d = 8'd0;
                end else begin
                    ring_cnt_d = ring_cnt_q - 8'd1;
                end
            end
        end else if (match && !match_q) begin
            ring_d     = 1'b1;
            ring_cnt_d = RingLoad;
        end
    end

    // State and output registers
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q    <= StRun;
            hour_inc_q <= 1'b0;
            min_inc_q  <= 1'b0;
            al_hour_q  <= 8'h00;
            al_min_q   <= 8'h00;
            alarm_en_q <= 1'b0;
            ring_q     <= 1'b0;
            ring_cnt_q <= 8'd0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            hour_inc_q <= hour_inc_d;
            min_inc_q  <= min_inc_d;
            al_hour_q  <= al_hour_d;
            al_min_q   <= al_min_d;
            alarm_en_q <= alarm_en_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
            match_q    <= match;
        end
    end

    // Tick gating and blink follow the current mode
    always_comb begin
        otick  = iclk_sec;
        oblink = 1'b0;
        if (state_q == StSetHour || state_q == StSetMin) otick = 1'b1;
        if (state_q != StRun) oblink = iclk_sec;
    end

    assign ohour_inc = hour_inc_q;
    assign omin_inc  = min_inc_q;
    assign omode     = state_q;
    assign oal_hour  = al_hour_q;
    assign oal_min   = al_min_q;
    assign oalarm_en = alarm_en_q;
    assign oring     = ring_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: mode cycling, set pulses, alarm BCD wrap,
// ring duration, dismissal, simultaneous keys and asynchronous reset.
module tb_clock_set_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_sec;
    logic       key_mode;
    logic       key_inc;
    logic [7:0] hour, min, sec;
    logic       tick, hour_inc, min_inc, blink, alarm_en, ring;
    logic [2:0] mode;
    logic [7:0] al_hour, al_min;

    int checks = 0;
    int errors = 0;
    int hour_pulses = 0, min_pulses = 0, wide_pulses = 0;
    logic hour_prev = 1'b0, min_prev = 1'b0;

    clock_set_ctrl #(.RING_SEC(3)) dut (
        .iclk      (clk),
        .irst_n    (rst_n),
        .iclk_sec  (clk_sec),
        .ikey_mode (key_mode),
        .ikey_inc  (key_inc),
        .ihour     (hour),
        .imin      (min),
        .isec      (sec),
        .otick     (tick),
        .ohour_inc (hour_inc),
        .omin_inc  (min_inc),
        .omode     (mode),
        .oblink    (blink),
        .oal_hour  (al_hour),
        .oal_min   (al_min),
        .oalarm_en (alarm_en),
        .oring     (ring)
    );

    always #5 clk = ~clk;

    // Pulse counters and width monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (hour_inc) hour_pulses <= hour_pulses + 1;
        if (min_inc)  min_pulses  <= min_pulses + 1;
        if ((hour_inc && hour_prev) || (min_inc && min_prev)) wide_pulses <= wide_pulses + 1;
        hour_prev <= hour_inc;
        min_prev  <= min_inc;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic m, input logic i);
        @(negedge clk);
        if (m) key_mode = 1'b0;
        if (i) key_inc = 1'b0;
        idle(6);
        key_mode = 1'b1;
        key_inc  = 1'b1;
        idle(6);
    endtask

    task automatic press_inc_n(input int n);
        for (int k = 0; k < n; k++) press(1'b0, 1'b1);
    endtask

    task automatic sec_fall();
        @(negedge clk);
        clk_sec = 1'b0;
        idle(6);
        clk_sec = 1'b1;
        idle(6);
    endtask

    logic [2:0] exp_mode [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    int h0, m0;

    initial begin
        rst_n = 1'b0; clk_sec = 1'b1; key_mode = 1'b1; key_inc = 1'b1;
        hour = 8'h00; min = 8'h00; sec = 8'h01;
        idle(3);
        check("rst_mode", mode, 3'd0);
        check("rst_al_hour", al_hour, 8'h00);
        check("rst_al_min", al_min, 8'h00);
        check("rst_alarm_en", alarm_en, 1'b0);
        check("rst_ring", ring, 1'b0);
        check("rst_incs", {hour_inc, min_inc}, 2'b00);
        rst_n = 1'b1;
        idle(4);

        // Mode cycle: tick gated only in SET states, blink in all non-RUN states
        for (int s = 0; s < 5; s++) begin
            press(1'b1, 1'b0);
            check("mode_cycle", mode, exp_mode[s]);
            check("blink_hi", blink, (exp_mode[s] != 3'd0) ? 1'b1 : 1'b0);
            clk_sec = 1'b0;
            @(negedge clk);
            check("tick_gate", tick, (exp_mode[s] == 3'd1 || exp_mode[s] == 3'd2) ? 1'b1 : 1'b0);
            check("blink_lo", blink, 1'b0);
            clk_sec = 1'b1;
            idle(6);
        end

        // SET_HOUR: three hour pulses, no minute pulses
        press(1'b1, 1'b0);
        h0 = hour_pulses; m0 = min_pulses;
        press_inc_n(3);
        check("set_hour_pulses", hour_pulses - h0, 3);
        check("set_hour_no_min", min_pulses - m0, 0);
        // SET_MIN: one minute pulse
        press(1'b1, 1'b0);
        check("mode_set_min", mode, 3'd2);
        press_inc_n(1);
        check("set_min_pulses", min_pulses - m0, 1);
        check("set_min_no_hour", hour_pulses - h0, 3);
        check("pulse_width", wide_pulses, 0);

        // AL_HOUR: 09 -> 10 -> 11 -> 00, then set 07
        press(1'b1, 1'b0);
        check("mode_al_hour", mode, 3'd3);
        press_inc_n(9);
        check("al_hour_09", al_hour, 8'h09);
        press_inc_n(1);
        check("al_hour_10", al_hour, 8'h10);
        press_inc_n(1);
        check("al_hour_11", al_hour, 8'h11);
        press_inc_n(1);
        check("al_hour_wrap", al_hour, 8'h00);
        press_inc_n(7);
        check("al_hour_07", al_hour, 8'h07);

        // AL_MIN: 58 -> 59 -> 00, then set 30
        press(1'b1, 1'b0);
        check("mode_al_min", mode, 3'd4);
        press_inc_n(58);
        check("al_min_58", al_min, 8'h58);
        press_inc_n(1);
        check("al_min_59", al_min, 8'h59);
        press_inc_n(1);
        check("al_min_wrap", al_min, 8'h00);
        press_inc_n(30);
        check("al_min_30", al_min, 8'h30);

        // Back to RUN and arm
        press(1'b1, 1'b0);
        check("mode_run", mode, 3'd0);
        press_inc_n(1);
        check("alarm_armed", alarm_en, 1'b1);

        // Ring at 07:30:00 for three 1 Hz falling edges
        @(negedge clk);
        hour = 8'h07; min = 8'h30; sec = 8'h00;
        idle(3);
        check("ring_start", ring, 1'b1);
        sec_fall();
        check("ring_after_1", ring, 1'b1);
        sec_fall();
        check("ring_after_2", ring, 1'b1);
        sec_fall();
        check("ring_after_3", ring, 1'b0);
        idle(10);
        check("ring_no_retrigger", ring, 1'b0);

        // New match rise, then dismiss with inc
        sec = 8'h01;
        idle(3);
        sec = 8'h00;
        idle(3);
        check("ring_restart", ring, 1'b1);
        press_inc_n(1);
        check("dismiss_ring", ring, 1'b0);
        check("dismiss_keeps_en", alarm_en, 1'b1);
        idle(20);
        check("dismiss_final", ring, 1'b0);

        // Mode and inc together in SET_HOUR: mode wins, no hour pulse
        press(1'b1, 1'b0);
        check("mode_set_hour2", mode, 3'd1);
        h0 = hour_pulses;
        press(1'b1, 1'b1);
        check("simul_mode", mode, 3'd2);
        check("simul_no_hour_inc", hour_pulses - h0, 0);

        // Asynchronous reset from AL_MIN with a programmed alarm
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("mode_al_min2", mode, 3'd4);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_mode", mode, 3'd0);
        check("async_rst_al_hour", al_hour, 8'h00);
        check("async_rst_al_min", al_min, 8'h00);
        check("async_rst_en", alarm_en, 1'b0);
        check("async_rst_ring", ring, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #2000000;
        errors++;
        $display("FAIL timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
